// File: rtl/reg_file_pkg.sv
// Shared constants and types for the 8x8 CPU register file.
package reg_file_pkg;
  localparam int DATA_W   = 8;
  localparam int NUM_REGS = 8;
  localparam int ADDR_W   = $clog2(NUM_REGS);

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;
endpackage

// File: rtl/reg_file_write_decoder.sv
// One-hot write select: drives per-register write enables and DIRTY set terms.
module write_decoder
  import reg_file_pkg::*;
(
  input  logic                i_we,
  input  reg_addr_t           i_addr,
  output logic [NUM_REGS-1:0] o_onehot
);
  always_comb begin
    o_onehot = '0;
    if (i_we) o_onehot[i_addr] = 1'b1;
  end
endmodule

// File: rtl/reg_file.sv
// 8x8 register file, two combinational read ports, per-register dirty mask.
// Optional write-through forwarding on reads when READ_BYPASS_EN is defined.
module reg_file
  import reg_file_pkg::*;
(
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic                WRITEENABLE,
  input  reg_addr_t           WRITEREG,
  input  reg_data_t           WRITEDATA,
  input  reg_addr_t           READREG1,
  input  reg_addr_t           READREG2,
  input  logic                CLEARDIRTY,
  output reg_data_t           REGOUT1,
  output reg_data_t           REGOUT2,
  output logic [NUM_REGS-1:0] DIRTY
);
  logic [NUM_REGS-1:0][DATA_W-1:0] r_regs;
  logic [NUM_REGS-1:0]             r_dirty;
  logic [NUM_REGS-1:0]             w_wsel;

  write_decoder u_dec (
    .i_we     (WRITEENABLE),
    .i_addr   (WRITEREG),
    .o_onehot (w_wsel)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_regs <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++)
        if (w_wsel[i]) r_regs[i] <= WRITEDATA;
    end
  end

  // Set term ORed after the clear so a same-cycle write keeps its bit.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) r_dirty <= '0;
    else          r_dirty <= (CLEARDIRTY ? '0 : r_dirty) | w_wsel;
  end

  assign DIRTY = r_dirty;

  always_comb begin
    REGOUT1 = r_regs[READREG1];
    REGOUT2 = r_regs[READREG2];
`ifdef READ_BYPASS_EN
    // Forwarded data must not leak through while reset holds the array at zero.
    if (WRITEENABLE && RESET_N && (READREG1 == WRITEREG)) REGOUT1 = WRITEDATA;
    if (WRITEENABLE && RESET_N && (READREG2 == WRITEREG)) REGOUT2 = WRITEDATA;
`endif
  end
endmodule

// File: tb/tb_reg_file.sv
// Directed, table-driven bench for reg_file plus hand-written reset/hazard sequences.
module tb_reg_file;
  import reg_file_pkg::*;

  logic                CLK = 1'b0;
  logic                RESET_N;
  logic                WRITEENABLE;
  reg_addr_t           WRITEREG;
  reg_data_t           WRITEDATA;
  reg_addr_t           READREG1;
  reg_addr_t           READREG2;
  logic                CLEARDIRTY;
  reg_data_t           REGOUT1;
  reg_data_t           REGOUT2;
  logic [NUM_REGS-1:0] DIRTY;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  reg_file dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .WRITEENABLE (WRITEENABLE),
    .WRITEREG    (WRITEREG),
    .WRITEDATA   (WRITEDATA),
    .READREG1    (READREG1),
    .READREG2    (READREG2),
    .CLEARDIRTY  (CLEARDIRTY),
    .REGOUT1     (REGOUT1),
    .REGOUT2     (REGOUT2),
    .DIRTY       (DIRTY)
  );

  typedef struct {
    logic                we;
    reg_addr_t           wreg;
    reg_data_t           wdata;
    logic                clr;
    reg_addr_t           rr1;
    reg_addr_t           rr2;
    reg_data_t           e1;
    reg_data_t           e2;
    logic [NUM_REGS-1:0] ed;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input int wreg, input int wdata, input logic clr,
                              input int rr1, input int rr2, input int e1, input int e2,
                              input int ed);
    vec_t v;
    v.we = we; v.wreg = reg_addr_t'(wreg); v.wdata = reg_data_t'(wdata); v.clr = clr;
    v.rr1 = reg_addr_t'(rr1); v.rr2 = reg_addr_t'(rr2);
    v.e1 = reg_data_t'(e1); v.e2 = reg_data_t'(e2); v.ed = NUM_REGS'(ed);
    return v;
  endfunction

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET_N = 1'b1; WRITEENABLE = 1'b0; WRITEREG = '0; WRITEDATA = '0;
    READREG1 = '0; READREG2 = '0; CLEARDIRTY = 1'b0;

    // Write/read of r3, then fill all registers and check dirty accumulation.
    tbl.push_back(mk(1, 3, 'hA5, 0, 3, 0, 'hA5, 'h00, 'h08));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(1, i, 'h10 + i, 0, i, 7, 'h10 + i, (i == 7) ? 'h17 : 'h00,
                       ((1 << (i + 1)) - 1) | 'h08));
    // Dual-port sweep: port 1 up, port 2 down.
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(0, 2, 'hEE, 0, i, 7 - i, 'h10 + i, 'h17 - i, 'hFF));
    // Both ports on the same register; WE=0 with junk address/data changes nothing.
    tbl.push_back(mk(0, 2, 'hEE, 0, 2, 2, 'h12, 'h12, 'hFF));
    // Clear collides with a write to r6: the write keeps its dirty bit.
    tbl.push_back(mk(1, 6, 'h66, 1, 6, 5, 'h66, 'h15, 'h40));
    tbl.push_back(mk(0, 0, 'h00, 1, 6, 0, 'h66, 'h10, 'h00));
    tbl.push_back(mk(1, 5, 'h11, 0, 7, 5, 'h17, 'h11, 'h20));

    // Power-on reset asserted mid-cycle.
    #3 RESET_N = 1'b0;
    #1;
    chk("reset_out1", REGOUT1, 8'h00);
    chk("reset_out2", REGOUT2, 8'h00);
    chk("reset_dirty", DIRTY, 8'h00);
    @(negedge CLK); RESET_N = 1'b1;

    foreach (tbl[k]) begin
      @(negedge CLK);
      WRITEENABLE = tbl[k].we; WRITEREG = tbl[k].wreg; WRITEDATA = tbl[k].wdata;
      CLEARDIRTY = tbl[k].clr; READREG1 = tbl[k].rr1; READREG2 = tbl[k].rr2;
      @(posedge CLK); #1;
      WRITEENABLE = 1'b0; CLEARDIRTY = 1'b0;
      #1;
      chk($sformatf("vec%0d_out1", k), REGOUT1, tbl[k].e1);
      chk($sformatf("vec%0d_out2", k), REGOUT2, tbl[k].e2);
      chk($sformatf("vec%0d_dirty", k), DIRTY, tbl[k].ed);
    end

    // Same-cycle read of the register being written (r5 holds 8'h11).
    @(negedge CLK);
    WRITEENABLE = 1'b1; WRITEREG = 3'd5; WRITEDATA = 8'h3C; READREG2 = 3'd5; READREG1 = 3'd6;
    #1;
`ifdef READ_BYPASS_EN
    chk("rdw_before_edge", REGOUT2, 8'h3C);
`else
    chk("rdw_before_edge", REGOUT2, 8'h11);
`endif
    chk("rdw_other_port", REGOUT1, 8'h66);
    @(posedge CLK); #1;
    chk("rdw_after_edge", REGOUT2, 8'h3C);
    WRITEENABLE = 1'b0;

    // Asynchronous reset mid-cycle with data present.
    @(negedge CLK); #2 RESET_N = 1'b0;
    #1;
    chk("areset_out1", REGOUT1, 8'h00);
    chk("areset_out2", REGOUT2, 8'h00);
    chk("areset_dirty", DIRTY, 8'h00);
    @(negedge CLK); RESET_N = 1'b1;
    @(negedge CLK);
    WRITEENABLE = 1'b1; WRITEREG = 3'd2; WRITEDATA = 8'h5A; READREG1 = 3'd2; READREG2 = 3'd6;
    @(posedge CLK); #1;
    WRITEENABLE = 1'b0;
    #1;
    chk("post_reset_r2", REGOUT1, 8'h5A);
    chk("post_reset_r6", REGOUT2, 8'h00);
    chk("post_reset_dirty", DIRTY, 8'h04);

    // Write to r2 in flight when reset asserts is lost, even with forwarding.
    @(negedge CLK);
    WRITEENABLE = 1'b1; WRITEREG = 3'd2; WRITEDATA = 8'h77; READREG1 = 3'd2; CLEARDIRTY = 1'b1;
    #1 RESET_N = 1'b0;
    #1;
    chk("inflight_out1_in_reset", REGOUT1, 8'h00);
    @(posedge CLK); #1;
    chk("inflight_dirty_in_reset", DIRTY, 8'h00);
    @(negedge CLK);
    RESET_N = 1'b1; WRITEENABLE = 1'b0; CLEARDIRTY = 1'b0;
    #1;
    chk("inflight_lost_r2", REGOUT1, 8'h00);
    chk("inflight_lost_dirty", DIRTY, 8'h00);
    @(negedge CLK);
    WRITEENABLE = 1'b1; WRITEREG = 3'd2; WRITEDATA = 8'h77;
    @(posedge CLK); #1;
    WRITEENABLE = 1'b0;
    #1;
    chk("recover_r2", REGOUT1, 8'h77);
    chk("recover_dirty", DIRTY, 8'h04);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
